// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - shared object-management constants, FSM states and matrix-unit encodings
package obj_pkg;

    localparam int NUM_OBJ = 32;
    localparam int IDX_W   = $clog2(NUM_OBJ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CRT_CAP = 2'd1,
        RESP    = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        GEO_NONE      = 2'd0,
        GEO_TRANSLATE = 2'd1,
        GEO_ROTATE    = 2'd2,
        GEO_SCALE     = 2'd3
    } geometric_op_t;

    typedef enum logic [1:0] {
        OBJ_POINT    = 2'd0,
        OBJ_LINE     = 2'd1,
        OBJ_TRIANGLE = 2'd2,
        OBJ_QUAD     = 2'd3
    } obj_type_t;

endpackage

// File: rtl/free_slot_finder.sv
// rtl/free_slot_finder.sv - combinational lowest-zero priority encoder over the slot map
module free_slot_finder
    import obj_pkg::*;
(
    input  logic [NUM_OBJ-1:0] valid_map,
    output logic [IDX_W-1:0]   idx,
    output logic               any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (!valid_map[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obj_slot_manager.sv
// rtl/obj_slot_manager.sv - object-slot allocation map servicing create/delete/reference requests
module obj_slot_manager
    import obj_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               crt_obj,
    input  logic               del_obj,
    input  logic               del_all,
    input  logic               ref_addr,
    input  logic [IDX_W-1:0]   obj_num_in,
    output logic               addr_vld,
    output logic [IDX_W-1:0]   obj_addr,
    output logic [IDX_W-1:0]   lst_stored_obj,
    output logic               lst_stored_obj_vld,
    output logic               obj_mem_full,
    output logic               req_err,
    output logic [IDX_W:0]     obj_count,
    output logic [NUM_OBJ-1:0] valid_map
);

    slot_state_t         r_state, w_state_nxt;
    logic [NUM_OBJ-1:0]  r_map, w_map_nxt;
    logic [IDX_W:0]      r_count, w_count_nxt;
    logic [IDX_W-1:0]    r_cap_idx, w_cap_idx_nxt;
    logic [IDX_W-1:0]    r_obj_addr, w_obj_addr_nxt;
    logic [IDX_W-1:0]    r_lst, w_lst_nxt;
    logic                r_lst_vld, w_lst_vld_nxt;
    logic                r_addr_vld, w_addr_vld_nxt;
    logic                r_req_err, w_req_err_nxt;
    logic                r_full;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_any_free;

    free_slot_finder u_free_slot_finder (
        .valid_map (r_map),
        .idx       (w_free_idx),
        .any_free  (w_any_free)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_map_nxt      = r_map;
        w_count_nxt    = r_count;
        w_cap_idx_nxt  = r_cap_idx;
        w_obj_addr_nxt = r_obj_addr;
        w_lst_nxt      = r_lst;
        w_lst_vld_nxt  = r_lst_vld;
        w_addr_vld_nxt = 1'b0;
        w_req_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (del_obj) begin
                    if (del_all) begin
                        w_map_nxt     = '0;
                        w_count_nxt   = '0;
                        w_lst_vld_nxt = 1'b0;
                    end else if (r_map[obj_num_in]) begin
                        w_map_nxt[obj_num_in] = 1'b0;
                        w_count_nxt           = r_count - (IDX_W+1)'(1);
                        if (obj_num_in == r_lst) begin
                            w_lst_vld_nxt = 1'b0;
                        end
                    end else begin
                        w_req_err_nxt = 1'b1;
                    end
                end else if (crt_obj) begin
                    if (r_full || !w_any_free) begin
                        w_req_err_nxt = 1'b1;
                    end else begin
                        w_cap_idx_nxt = w_free_idx;
                        w_state_nxt   = CRT_CAP;
                    end
                end else if (ref_addr) begin
                    if (r_map[obj_num_in]) begin
                        w_addr_vld_nxt = 1'b1;
                        w_obj_addr_nxt = obj_num_in;
                    end else begin
                        w_req_err_nxt = 1'b1;
                    end
                end
            end
            CRT_CAP: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                // The map commit and the addr_vld pulse land on the same edge.
                w_state_nxt          = IDLE;
                w_addr_vld_nxt       = 1'b1;
                w_obj_addr_nxt       = r_cap_idx;
                w_map_nxt[r_cap_idx] = 1'b1;
                w_count_nxt          = r_count + (IDX_W+1)'(1);
                w_lst_nxt            = r_cap_idx;
                w_lst_vld_nxt        = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_map      <= '0;
            r_count    <= '0;
            r_cap_idx  <= '0;
            r_obj_addr <= '0;
            r_lst      <= '0;
            r_lst_vld  <= 1'b0;
            r_addr_vld <= 1'b0;
            r_req_err  <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_map      <= w_map_nxt;
            r_count    <= w_count_nxt;
            r_cap_idx  <= w_cap_idx_nxt;
            r_obj_addr <= w_obj_addr_nxt;
            r_lst      <= w_lst_nxt;
            r_lst_vld  <= w_lst_vld_nxt;
            r_addr_vld <= w_addr_vld_nxt;
            r_req_err  <= w_req_err_nxt;
            r_full     <= (w_count_nxt == (IDX_W+1)'(NUM_OBJ));
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        r_count <= (IDX_W+1)'(NUM_OBJ));
    a_count_matches_map: assert property (@(posedge clk) disable iff (rst)
        r_count == (IDX_W+1)'($countones(r_map)));

    assign addr_vld           = r_addr_vld;
    assign obj_addr           = r_obj_addr;
    assign lst_stored_obj     = r_lst;
    assign lst_stored_obj_vld = r_lst_vld;
    assign obj_mem_full       = r_full;
    assign req_err            = r_req_err;
    assign obj_count          = r_count;
    assign valid_map          = r_map;

endmodule

// File: doc/obj_slot_manager.md
Name: obj_slot_manager

Overview:
- Responder end of the object-management handshake driven by the matrix unit.
- Owns the 32-entry object-slot allocation map and services create, delete, delete-all and reference-address requests.
- Returns slot indices through an addr_vld pulse and publishes the last stored object, the full flag and the occupancy.
- The video memory unit uses obj_addr as its object row address. Clipping and raster units scan valid_map.

Parameters:
- NUM_OBJ, 32, number of object slots; must be a power of two.
- IDX_W, 5, slot index width, equal to log2(NUM_OBJ).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- crt_obj  in  1  allocate the lowest free slot; single-cycle request.
- del_obj  in  1  free slot obj_num_in; single-cycle request.
- del_all  in  1  qualifies del_obj; when 1, free every slot.
- ref_addr  in  1  look up existing slot obj_num_in.
- obj_num_in  in  IDX_W  target slot for del_obj and ref_addr.
- addr_vld  out  1  one-cycle pulse; obj_addr is valid in that cycle.
- obj_addr  out  IDX_W  slot index for video memory read/write.
- lst_stored_obj  out  IDX_W  index of the most recently created object.
- lst_stored_obj_vld  out  1  lst_stored_obj refers to a live slot.
- obj_mem_full  out  1  all NUM_OBJ slots are occupied.
- req_err  out  1  one-cycle pulse; the request was rejected.
- obj_count  out  IDX_W+1  number of occupied slots, 0..32.
- valid_map  out  NUM_OBJ  per-slot occupancy bits.

Behaviour:
- Reset values: all outputs 0, valid_map 0, FSM in IDLE. Reset wins over any request in the same cycle and aborts an in-flight operation with no addr_vld.
- States:
  - IDLE: accepts requests.
  - CRT_CAP: registers the free-slot encoder result.
  - RESP: commits and pulses.
- Request acceptance: requests are sampled only in IDLE. Requests arriving in CRT_CAP or RESP are ignored with no req_err; the initiator holds busy, so none arrive legitimately.
- Priority in IDLE when requests are simultaneous: del_obj > crt_obj > ref_addr. Lower-priority requests in that cycle are dropped.
- crt_obj with obj_mem_full=0:
  - IDLE -> CRT_CAP: the lowest-index zero of valid_map is latched.
  - CRT_CAP -> RESP: the latched index is driven.
  - RESP -> IDLE. In RESP: addr_vld=1, obj_addr=idx, valid_map[idx] set, obj_count+1, lst_stored_obj=idx, lst_stored_obj_vld=1.
  - Latency: request at edge N, addr_vld high in the cycle after edge N+2.
- crt_obj with obj_mem_full=1: stays in IDLE, req_err pulses the next cycle, no state change.
- del_obj, del_all=0:
  - Slot valid: clear the bit and decrement obj_count at the next edge. No addr_vld.
  - Slot not valid: req_err pulse, no other change.
  - If the deleted slot equals lst_stored_obj, clear lst_stored_obj_vld; lst_stored_obj keeps its value.
- del_all=1: valid_map=0, obj_count=0, lst_stored_obj_vld=0 in one edge. Never raises req_err, even when already empty.
- ref_addr:
  - Slot valid: next cycle addr_vld=1 and obj_addr=obj_num_in. Used for read-modify-write by the video memory.
  - Slot not valid: req_err pulse, no addr_vld.
- obj_mem_full is registered and equals (obj_count==NUM_OBJ). It updates on the same edge as the map.
- obj_addr holds its last value when addr_vld=0.
- Counter saturation: obj_count never exceeds NUM_OBJ and never underflows. The guards above guarantee this; assert it in simulation.

Decomposition:
- Shared package obj_pkg holds:
  - NUM_OBJ and IDX_W;
  - the state enum (IDLE, CRT_CAP, RESP);
  - the geometric_op and obj_type encodings, so the matrix unit and this block share them.
- One sub-module, free_slot_finder: a purely combinational lowest-zero priority encoder. Input valid_map; outputs idx and any_free.

Test Plan:
- After reset, three crt_obj requests, each waiting for addr_vld -> obj_addr 0, 1, 2 each two cycles after request; obj_count=3; lst_stored_obj=2 with vld=1.
- With slots 0-2 live, del_obj on slot 1, then crt_obj -> allocation reuses slot 1; lst_stored_obj=1; obj_count=3.
- Fill all 32 slots -> obj_mem_full=1 with obj_count=32; a further crt_obj -> req_err pulse, no addr_vld, map unchanged.
- ref_addr on slot 5 (live) -> addr_vld with obj_addr=5 next cycle. ref_addr and del_obj on slot 9 (free) -> req_err only.
- del_obj and crt_obj in the same IDLE cycle -> only the delete takes effect. Then del_all -> valid_map=0, obj_count=0, obj_mem_full=0, lst_stored_obj_vld=0.
- Assert rst during CRT_CAP -> no addr_vld; all outputs 0 on the next cycle; the next crt_obj returns slot 0.
